// File: rtl/calc_pkg.sv
// Shared definitions for the two-requester calculator arbiter.
// Opcodes, FSM state encoding and the default datapath width.
package calc_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/calc_core.sv
// Combinational four-function unsigned calculator.
// Results wrap to WIDTH bits; divide by zero gives all ones.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_zero
);

  // Select the requested function; only div can flag an error.
  always_comb begin
    o_result   = '0;
    o_div_zero = 1'b0;
    unique case (i_op)
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_MUL: o_result = i_a * i_b;
      OP_DIV: begin
        if (i_b == '0) begin
          o_result   = '1;
          o_div_zero = 1'b1;
        end else begin
          o_result = i_a / i_b;
        end
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin sharing of one calculator between two requesters.
// Accept, execute, then hold a tagged result until consumed.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [1:0]       i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [1:0]       i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_err;

  logic             w_sel1;
  logic             w_accept;
  logic [WIDTH-1:0] w_core_res;
  logic             w_core_dz;

  // Requester 1 wins when alone or when the pointer favours it.
  assign w_sel1   = i_req1_valid & (~i_req0_valid | r_ptr);
  assign w_accept = o_req0_ready | o_req1_ready;

  calc_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_result  (w_core_res),
    .o_div_zero(w_core_dz)
  );

  // Next state and combinational grants; nothing granted in reset.
  always_comb begin
    w_state_nxt  = r_state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_req0_ready = i_req0_valid & ~w_sel1 & ~i_rst;
        o_req1_ready = w_sel1 & ~i_rst;
        if (i_req0_valid | i_req1_valid) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand latches, response registers and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr        <= 1'b0;
      r_op         <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= o_req1_ready ? i_req1_op : i_req0_op;
        r_a  <= o_req1_ready ? i_req1_a  : i_req0_a;
        r_b  <= o_req1_ready ? i_req1_b  : i_req0_b;
        r_id <= o_req1_ready;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_id;
        r_rsp_result <= w_core_res;
        r_rsp_err    <= w_core_dz;
      end
      if (r_state == ST_RESP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_ptr       <= ~r_rsp_id;
      end
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_err    = r_rsp_err;

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Sequencing controller that shares one WIDTH-bit four-function calculator datapath (add, sub, mul, div) between two requesters. It arbitrates round-robin between the requesters, latches the winner's operands, runs one operation, and returns a registered, tagged result through a valid/ready response port. It sits between requesting control blocks and the combinational calculator core.

## Interface
- WIDTH, 4, operand and result width in bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- req0_a, req0_b  in  WIDTH  operands; the result is a op b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that issued the operation.
- rsp_result  out  WIDTH  operation result.
- rsp_err  out  1  division by zero.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: operands latched; calculator output is being registered.
  - RESP: result is held on the response port.
- IDLE:
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the one selected by priority pointer `ptr`.
  - reqN_ready = (state==IDLE) && reqN_valid && granted. It is combinational, and at most one ready is high.
  - On the handshake: latch op, a, b and id, then go to EXEC.
- EXEC: register the core output into rsp_result and rsp_err, set rsp_valid, then go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_result and rsp_err stable until rsp_valid && rsp_ready.
  - On that handshake: clear rsp_valid, set ptr = ~rsp_id, return to IDLE.
- Arithmetic (unsigned, WIDTH bits):
  - add, sub and mul wrap modulo 2^WIDTH; the upper product bits are discarded.
  - div is floor(a/b).
  - b==0 on div gives result all ones and rsp_err=1. rsp_err is 0 for every other case.
- Requesters hold op, a and b stable while valid is high and ready is low. The block does not check this.
- While not in IDLE, both ready outputs are 0 regardless of valid.

## Timing
- Reset values:
  - state=IDLE, ptr=0 (requester 0 favoured), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - req0_ready=0 and req1_ready=0 during any cycle in which rst is high.
- Latency:
  - Request handshake in cycle N gives rsp_valid high from cycle N+2.
  - The earliest next request handshake is cycle N+3, when rsp_ready is high in N+2.
  - Peak throughput is one operation per 3 cycles.
- Simultaneous valid: only the ptr-selected requester sees ready. The other waits at least one full operation.
- Round-robin: with both requesters continuously valid, grants strictly alternate.
- Backpressure: rsp_ready low holds the block in RESP indefinitely with outputs unchanged.
- Reset mid-operation (EXEC or RESP): the next cycle is IDLE with rsp_valid=0. The in-flight result is discarded and never presented.
- rsp_ready while rsp_valid=0 has no effect.

## Structure
- Shared package `calc_pkg`:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - FSM state encoding (IDLE, EXEC, RESP).
  - default WIDTH.
- One sub-module, `calc_core`: combinational WIDTH-parameterised datapath.
  - Inputs: op, a, b.
  - Outputs: result, div_zero.
  - It has the four functions and the divide-by-zero rule above.
- `calc_arbiter` contains the FSM, ptr, operand latches and response registers, and instantiates `calc_core` once.

## Test plan
All scenarios use WIDTH=4.
- Reset, then req0 add a=2 b=2 only, handshake at cycle N -> rsp_valid at N+2, result 4, id 0, err 0.
- Both valid after reset: req0 sub 2-3, req1 mul 3*6 -> first response id 0 result 4'hF. Second response id 1 result 4'h2 (18 mod 16).
- Both requesters held valid for 6 operations with rsp_ready=1 -> ids 0,1,0,1,0,1; requester handshakes 3 cycles apart.
- req1 div 7/0 -> result 4'hF, err 1. Then req1 div 7/2 -> result 3, err 0.
- rsp_ready low for 5 cycles in RESP, req0 valid meanwhile -> response fields stable, req0_ready stays 0. Raise rsp_ready -> req0 accepted the cycle after the response handshake.
- rst pulsed for one cycle during EXEC -> rsp_valid never asserts for that operation. With only req1 valid afterwards, req1 is accepted in the first cycle after rst falls.
